mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Requester-side controller for the 256x32 unified program/data memory (async read port, sync write port).
- Arbitrates the core's instruction-fetch channel and load/store channel onto the memory's ADDRESS_READ / ADDRESS_WRITE / DATA_IN / WRITE_ENABLE pins.
- Registers read data from DATA_OUT and returns responses to the core over valid/ready handshakes.
- Sits between the CPU datapath/control and MEMORY.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory word width.
- STARVE_MAX, 4, consecutive data-channel grants allowed while a fetch waits before fetch is forced.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IF_REQ_VALID  in  1  fetch request valid.
- IF_REQ_READY  out  1  fetch request accepted this cycle.
- IF_ADDR  in  ADDR_W  fetch address (PC).
- IF_RSP_VALID  out  1  fetched instruction valid.
- IF_RSP_READY  in  1  core accepts instruction.
- IF_RSP_DATA  out  DATA_W  fetched instruction.
- LS_REQ_VALID  in  1  load/store request valid.
- LS_REQ_READY  out  1  load/store request accepted.
- LS_WE  in  1  1 = store, 0 = load.
- LS_ADDR  in  ADDR_W  data address.
- LS_WDATA  in  DATA_W  store data.
- LS_RSP_VALID  out  1  load data valid or store acknowledged.
- LS_RSP_READY  in  1  core accepts LS response.
- LS_RSP_DATA  out  DATA_W  load data; 0 for store acks.
- MEM_ADDRESS_READ  out  ADDR_W  to memory ADDRESS_READ.
- MEM_DATA_OUT  in  DATA_W  from memory DATA_OUT (combinational).
- MEM_ADDRESS_WRITE  out  ADDR_W  to memory ADDRESS_WRITE.
- MEM_DATA_IN  out  DATA_W  to memory DATA_IN.
- MEM_WRITE_ENABLE  out  1  to memory WRITE_ENABLE.

Behaviour:
- Reset (sync, CLK edge with RESET=1): state=IDLE; all *_READY, *_RSP_VALID, MEM_WRITE_ENABLE = 0; response data regs, MEM address/data regs = 0; starve counter = 0.
- Reset mid-operation: any in-flight request and undelivered response are dropped; a store is never committed after reset is sampled.
- FSM states: IDLE, ACCESS, IF_RSP, LS_RSP.
- IDLE:
  - REQ_READY is combinational, asserted only in IDLE, for the granted channel only.
  - Grant: LS over IF, unless IF_REQ_VALID and starve counter == STARVE_MAX, in which case IF is granted.
  - Handshake occurs when valid & ready. Latch channel id, WE, address and wdata; go to ACCESS.
  - No valid request: stay in IDLE.
- Starve counter: increments on each LS grant while IF_REQ_VALID=1; clears on IF grant or when IF_REQ_VALID=0; saturates at STARVE_MAX.
- ACCESS (exactly 1 cycle):
  - Read: drive MEM_ADDRESS_READ = latched address; capture MEM_DATA_OUT into the response register at the end of the cycle.
  - Store: assert MEM_WRITE_ENABLE for this single cycle with the latched MEM_ADDRESS_WRITE/MEM_DATA_IN. The write commits on the closing edge.
  - Next state: IF_RSP or LS_RSP.
- IF_RSP / LS_RSP: RSP_VALID=1; data held stable until RSP_READY; on handshake return to IDLE.
- Latency: request accepted at edge N, response valid from cycle N+2. Minimum 3 cycles per transaction; one transaction outstanding at a time.
- Read-after-write: a load following a store to the same address returns the new data, because the write commits before the load's ACCESS cycle.
- MEM_WRITE_ENABLE is never asserted outside ACCESS-with-store.
- MEM_ADDRESS_READ holds its last value when idle.
- Address width is exact; no wrap logic is needed (the 8-bit address covers 0..255).
- Request inputs are ignored while not in IDLE. A request must remain stable while valid & !ready.

Decomposition:
- Shared package mem_pkg: ADDR_W/DATA_W constants, FSM state encoding, channel-id encoding (CH_IF=0, CH_LS=1).
- One natural sub-module: mem_arbiter, the combinational priority plus starve counter, outputting grant_if and grant_ls.

Test Plan:
- Fetch after reset: memory preloaded with word 0 = 0x80400002; IF_ADDR=0, IF_REQ_VALID=1, IF_RSP_READY=1 -> IF_REQ_READY at cycle 0, IF_RSP_VALID with 0x80400002 two cycles later, then IDLE.
- Store then load: store 0xDEADBEEF to address 20, then load address 20 -> MEM_WRITE_ENABLE high exactly one cycle with MEM_ADDRESS_WRITE=20; LS_RSP_DATA=0xDEADBEEF.
- Contention/starvation: IF and LS valid continuously, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS... with the counter cleared after the IF grant.
- Backpressure: load address 11 (0x55555555) with LS_RSP_READY low for 5 cycles -> LS_RSP_VALID stays high with data stable, no new request accepted, completes one cycle after READY rises.
- Reset mid-store: RESET asserted on the ACCESS cycle of a store to address 30 -> MEM_WRITE_ENABLE=0 at that edge, address 30 unchanged, all valids 0 the next cycle.
- Idle: no requests for 10 cycles -> MEM_WRITE_ENABLE stays 0 and no RSP_VALID pulses.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the unified-memory requester: widths, controller
// state encoding and channel identifiers.
package mem_pkg;

  localparam int MEM_ADDR_W     = 8;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_STARVE_MAX = 4;

  // Controller states (kept as plain constants for older tools).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_IF_RSP = 2'd2;
  localparam logic [1:0] ST_LS_RSP = 2'd3;

  // Channel id of the transaction in flight.
  localparam logic CH_IF = 1'b0;
  localparam logic CH_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter. Load/store normally wins; a waiting fetch is
// forced through once STARVE_MAX consecutive load/store grants went by.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic CLK,
  input  logic RESET,
  input  logic idle,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  assign force_if = if_valid && (starve_cnt == CNT_MAX);
  assign grant_if = idle && if_valid && (!ls_valid || force_if);
  assign grant_ls = idle && ls_valid && !force_if;

  // Count load/store grants taken while a fetch is waiting; saturate at max.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= '0;
    end else if (grant_if || !if_valid) begin
      starve_cnt <= '0;
    end else if (grant_ls && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Requester-side controller for the 256x32 unified program/data memory.
// Serialises fetch and load/store requests onto the memory pins, one
// transaction at a time: IDLE -> ACCESS -> IF_RSP/LS_RSP -> IDLE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds its payload stable while valid && !ready.
// Request ready is combinational and only high in IDLE for the granted
// channel; response valid stays high with stable data until ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ_VALID,
  output logic              IF_REQ_READY,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_RSP_VALID,
  input  logic              IF_RSP_READY,
  output logic [DATA_W-1:0] IF_RSP_DATA,
  input  logic              LS_REQ_VALID,
  output logic              LS_REQ_READY,
  input  logic              LS_WE,
  input  logic [ADDR_W-1:0] LS_ADDR,
  input  logic [DATA_W-1:0] LS_WDATA,
  output logic              LS_RSP_VALID,
  input  logic              LS_RSP_READY,
  output logic [DATA_W-1:0] LS_RSP_DATA,
  output logic [ADDR_W-1:0] MEM_ADDRESS_READ,
  input  logic [DATA_W-1:0] MEM_DATA_OUT,
  output logic [ADDR_W-1:0] MEM_ADDRESS_WRITE,
  output logic [DATA_W-1:0] MEM_DATA_IN,
  output logic              MEM_WRITE_ENABLE
);

  logic [1:0] state;
  logic       ch_q;
  logic       we_q;
  logic       idle;
  logic       grant_if;
  logic       grant_ls;

  assign idle = (state == ST_IDLE);

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arbiter (
    .CLK     (CLK),
    .RESET   (RESET),
    .idle    (idle),
    .if_valid(IF_REQ_VALID),
    .ls_valid(LS_REQ_VALID),
    .grant_if(grant_if),
    .grant_ls(grant_ls)
  );

  assign IF_REQ_READY = grant_if;
  assign LS_REQ_READY = grant_ls;
  assign IF_RSP_VALID = (state == ST_IF_RSP);
  assign LS_RSP_VALID = (state == ST_LS_RSP);

  // The store commits on the edge closing ACCESS; a reset sampled on that
  // same edge must suppress it, hence the direct RESET term.
  assign MEM_WRITE_ENABLE = (state == ST_ACCESS) && we_q && !RESET;

  // Transaction sequencing: accept in IDLE, one ACCESS cycle, then respond.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      ch_q  <= CH_IF;
      we_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            ch_q  <= CH_LS;
            we_q  <= LS_WE;
            state <= ST_ACCESS;
          end else if (grant_if) begin
            ch_q  <= CH_IF;
            we_q  <= 1'b0;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= (ch_q == CH_LS) ? ST_LS_RSP : ST_IF_RSP;
        ST_IF_RSP: if (IF_RSP_READY) state <= ST_IDLE;
        ST_LS_RSP: if (LS_RSP_READY) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Address/data latching at acceptance and read-data capture after ACCESS.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_ADDRESS_READ  <= '0;
      MEM_ADDRESS_WRITE <= '0;
      MEM_DATA_IN       <= '0;
      IF_RSP_DATA       <= '0;
      LS_RSP_DATA       <= '0;
    end else begin
      if (grant_ls && LS_WE) begin
        MEM_ADDRESS_WRITE <= LS_ADDR;
        MEM_DATA_IN       <= LS_WDATA;
      end else if (grant_ls) begin
        MEM_ADDRESS_READ <= LS_ADDR;
      end else if (grant_if) begin
        MEM_ADDRESS_READ <= IF_ADDR;
      end
      if (state == ST_ACCESS) begin
        if (ch_q == CH_IF) begin
          IF_RSP_DATA <= MEM_DATA_OUT;
        end else begin
          LS_RSP_DATA <= we_q ? '0 : MEM_DATA_OUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: memory model, queue-fed request drivers, a
// negedge monitor holding a transaction-level reference model, directed
// scenarios followed by randomized traffic.
module tb_mem_access_unit;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ls_req_t;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic          IF_REQ_VALID = 1'b0;
  logic          IF_REQ_READY;
  logic [AW-1:0] IF_ADDR = '0;
  logic          IF_RSP_VALID;
  logic          IF_RSP_READY = 1'b1;
  logic [DW-1:0] IF_RSP_DATA;
  logic          LS_REQ_VALID = 1'b0;
  logic          LS_REQ_READY;
  logic          LS_WE = 1'b0;
  logic [AW-1:0] LS_ADDR = '0;
  logic [DW-1:0] LS_WDATA = '0;
  logic          LS_RSP_VALID;
  logic          LS_RSP_READY = 1'b1;
  logic [DW-1:0] LS_RSP_DATA;
  logic [AW-1:0] MEM_ADDRESS_READ;
  logic [DW-1:0] MEM_DATA_OUT;
  logic [AW-1:0] MEM_ADDRESS_WRITE;
  logic [DW-1:0] MEM_DATA_IN;
  logic          MEM_WRITE_ENABLE;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ_VALID(IF_REQ_VALID), .IF_REQ_READY(IF_REQ_READY), .IF_ADDR(IF_ADDR),
    .IF_RSP_VALID(IF_RSP_VALID), .IF_RSP_READY(IF_RSP_READY), .IF_RSP_DATA(IF_RSP_DATA),
    .LS_REQ_VALID(LS_REQ_VALID), .LS_REQ_READY(LS_REQ_READY), .LS_WE(LS_WE),
    .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
    .LS_RSP_VALID(LS_RSP_VALID), .LS_RSP_READY(LS_RSP_READY), .LS_RSP_DATA(LS_RSP_DATA),
    .MEM_ADDRESS_READ(MEM_ADDRESS_READ), .MEM_DATA_OUT(MEM_DATA_OUT),
    .MEM_ADDRESS_WRITE(MEM_ADDRESS_WRITE), .MEM_DATA_IN(MEM_DATA_IN),
    .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE)
  );

  // ---------------- memory: async read, sync write ----------------
  logic [DW-1:0] mem [256];
  assign MEM_DATA_OUT = mem[MEM_ADDRESS_READ];
  always @(posedge CLK) if (MEM_WRITE_ENABLE) mem[MEM_ADDRESS_WRITE] <= MEM_DATA_IN;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] ls_exp_q[$];
  logic [AW-1:0] if_req_q[$];
  ls_req_t       ls_req_q[$];
  logic          grant_log[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  logic if_hs = 1'b0, ls_hs = 1'b0;
  logic gap_en = 1'b0;
  int   if_rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
  int   ls_rdy_mode = 0;

  task automatic push_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ls_req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    ls_req_q.push_back(r);
  endtask

  // Present queued requests, hold them until accepted, drive response readies.
  always @(posedge CLK) begin
    ls_req_t r;
    #1;
    if (RESET) begin
      IF_REQ_VALID = 1'b0;
      LS_REQ_VALID = 1'b0;
      if_req_q.delete();
      ls_req_q.delete();
    end else begin
      if (IF_REQ_VALID && if_hs) IF_REQ_VALID = 1'b0;
      if (!IF_REQ_VALID && if_req_q.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
        IF_ADDR = if_req_q.pop_front();
        IF_REQ_VALID = 1'b1;
      end
      if (LS_REQ_VALID && ls_hs) LS_REQ_VALID = 1'b0;
      if (!LS_REQ_VALID && ls_req_q.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
        r = ls_req_q.pop_front();
        LS_WE = r.we; LS_ADDR = r.addr; LS_WDATA = r.wdata;
        LS_REQ_VALID = 1'b1;
      end
    end
    IF_RSP_READY = (if_rdy_mode == 0) ? 1'b1 : (if_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    LS_RSP_READY = (ls_rdy_mode == 0) ? 1'b1 : (ls_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // ---------------- monitor with reference model ----------------
  logic          busy = 1'b0;
  logic          out_ls = 1'b0;
  logic          out_we = 1'b0;
  logic [AW-1:0] out_addr = '0;
  logic [DW-1:0] out_wdata = '0;
  int            age = 0;
  int            cnt = 0;
  logic          log_en = 1'b0;

  always @(negedge CLK) begin
    logic exp_gi, exp_gl, exp_iv, exp_lv;
    if (RESET) begin
      if (busy) check("we_under_reset", MEM_WRITE_ENABLE, 1'b0);
      busy = 1'b0; cnt = 0; if_hs = 1'b0; ls_hs = 1'b0;
      if_exp_q.delete(); ls_exp_q.delete();
    end else begin
      if (busy) age++;
      exp_gi = !busy && IF_REQ_VALID && (!LS_REQ_VALID || cnt == SMAX);
      exp_gl = !busy && LS_REQ_VALID && !(IF_REQ_VALID && cnt == SMAX);
      check("if_req_ready", IF_REQ_READY, exp_gi);
      check("ls_req_ready", LS_REQ_READY, exp_gl);
      exp_iv = busy && !out_ls && age >= 2;
      exp_lv = busy && out_ls && age >= 2;
      check("if_rsp_valid", IF_RSP_VALID, exp_iv);
      check("ls_rsp_valid", LS_RSP_VALID, exp_lv);
      if (exp_iv && if_exp_q.size() > 0) check("if_rsp_data", IF_RSP_DATA, if_exp_q[0]);
      if (exp_lv && ls_exp_q.size() > 0) check("ls_rsp_data", LS_RSP_DATA, ls_exp_q[0]);
      if (busy && age == 1 && out_we) begin
        check("mem_we_store", MEM_WRITE_ENABLE, 1'b1);
        check("mem_waddr", MEM_ADDRESS_WRITE, out_addr);
        check("mem_wdata", MEM_DATA_IN, out_wdata);
        ref_mem[out_addr] = out_wdata;
      end else begin
        check("mem_we_quiet", MEM_WRITE_ENABLE, 1'b0);
      end
      if (busy && age == 1 && !out_we) check("mem_raddr", MEM_ADDRESS_READ, out_addr);
      // response handshakes
      if (IF_RSP_VALID && IF_RSP_READY) begin
        if (if_exp_q.size() > 0) void'(if_exp_q.pop_front());
        busy = 1'b0;
      end
      if (LS_RSP_VALID && LS_RSP_READY) begin
        if (ls_exp_q.size() > 0) void'(ls_exp_q.pop_front());
        busy = 1'b0;
      end
      // request handshakes
      if_hs = IF_REQ_VALID && IF_REQ_READY;
      ls_hs = LS_REQ_VALID && LS_REQ_READY;
      if (if_hs && ls_hs) check("dual_grant", 1'b1, 1'b0);
      if (ls_hs) begin
        busy = 1'b1; age = 0; out_ls = 1'b1; out_we = LS_WE;
        out_addr = LS_ADDR; out_wdata = LS_WDATA;
        ls_exp_q.push_back(LS_WE ? '0 : ref_mem[LS_ADDR]);
        if (log_en) grant_log.push_back(1'b1);
      end else if (if_hs) begin
        busy = 1'b1; age = 0; out_ls = 1'b0; out_we = 1'b0; out_addr = IF_ADDR;
        if_exp_q.push_back(ref_mem[IF_ADDR]);
        if (log_en) grant_log.push_back(1'b0);
      end
      if (if_hs || !IF_REQ_VALID) cnt = 0;
      else if (ls_hs && cnt < SMAX) cnt++;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_idle(input int budget);
    int n = 0;
    while (if_req_q.size() > 0 || ls_req_q.size() > 0 || IF_REQ_VALID || LS_REQ_VALID || busy) begin
      @(posedge CLK); #3;
      n++;
      if (n > budget) begin
        n_vec++; n_err++;
        $display("FAIL wait_idle: timeout after %0d cycles at %0t", budget, $time);
        break;
      end
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] old30;
    logic          exp_order [10];
    int            n, bad;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 0) v = 32'h8040_0002;
      if (i == 11) v = 32'h5555_5555;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;

    // reset state
    @(negedge CLK); #1;
    check("rst_raddr", MEM_ADDRESS_READ, '0);
    check("rst_waddr", MEM_ADDRESS_WRITE, '0);
    check("rst_wdata", MEM_DATA_IN, '0);
    check("rst_if_data", IF_RSP_DATA, '0);
    check("rst_ls_data", LS_RSP_DATA, '0);
    @(posedge CLK); #3;

    // fetch after reset
    if_req_q.push_back(8'd0);
    wait_idle(50);

    // store then load to the same address
    push_ls(1'b1, 8'd20, 32'hDEAD_BEEF);
    push_ls(1'b0, 8'd20, 32'h0);
    wait_idle(50);
    check("mem20_written", mem[20], 32'hDEAD_BEEF);

    // contention: fetch forced after SMAX load/store grants
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    grant_log.delete();
    log_en = 1'b1;
    if_req_q.push_back(8'd1);
    if_req_q.push_back(8'd2);
    for (int i = 0; i < 8; i++) push_ls(1'b0, 8'(100 + i), 32'h0);
    wait_idle(200);
    log_en = 1'b0;
    check("grant_count", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[i]);

    // backpressure on the load/store response
    ls_rdy_mode = 2;
    push_ls(1'b0, 8'd11, 32'h0);
    n = 0;
    while (!LS_RSP_VALID && n < 20) begin @(posedge CLK); #3; n++; end
    check("bp_rsp_seen", LS_RSP_VALID, 1'b1);
    if_req_q.push_back(8'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #3;
      check("bp_valid_held", LS_RSP_VALID, 1'b1);
      check("bp_data_stable", LS_RSP_DATA, 32'h5555_5555);
    end
    ls_rdy_mode = 0;
    @(posedge CLK); #3;
    @(posedge CLK); #3;
    check("bp_completed", LS_RSP_VALID, 1'b0);
    wait_idle(50);

    // reset during the ACCESS cycle of a store
    old30 = ref_mem[30];
    push_ls(1'b1, 8'd30, 32'hA5A5_A5A5);
    n = 0;
    do begin @(posedge CLK); #3; n++; end while (!ls_hs && n < 20);
    check("rst_store_accepted", ls_hs, 1'b1);
    RESET = 1'b1;
    @(posedge CLK); #3;
    RESET = 1'b0;
    @(negedge CLK); #1;
    check("rst_mid_if_valid", IF_RSP_VALID, 1'b0);
    check("rst_mid_ls_valid", LS_RSP_VALID, 1'b0);
    check("rst_mid_mem30", mem[30], old30);
    @(posedge CLK); #3;
    push_ls(1'b0, 8'd30, 32'h0);
    wait_idle(50);

    // idle: nothing may move
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #3;
      if (MEM_WRITE_ENABLE || IF_RSP_VALID || LS_RSP_VALID) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // randomized mixed traffic
    gap_en = 1'b1;
    if_rdy_mode = 1;
    ls_rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      if_req_q.push_back(8'($urandom_range(0, 31)));
      push_ls(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
    end
    wait_idle(5000);
    gap_en = 1'b0;
    if_rdy_mode = 0;
    ls_rdy_mode = 0;
    repeat (3) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
